// File: rtl/oam_dma_arbiter.sv
// OAM DMA arbiter: passes CPU accesses through to the shared bus until the CPU
// writes the DMA register. It then stalls the CPU and copies one 256-byte page
// into OAM as read/write pairs aligned to the even half of the parity clock.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_mem_r_en,
  input  logic [7:0]  cpu_w_data,
  output logic [7:0]  cpu_r_data,
  output logic        cpu_stall,
  output logic [15:0] bus_address,
  output logic        bus_mem_r_en,
  output logic [7:0]  bus_w_data,
  input  logic [7:0]  bus_r_data,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  buffer_q, buffer_d;
  logic        parity_q;

  // Read data is always returned straight from the bus.
  assign cpu_r_data = bus_r_data;

  // State register with asynchronous clear; parity free-runs out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      buffer_q <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      index_q  <= index_d;
      buffer_q <= buffer_d;
      parity_q <= ~parity_q;
    end
  end

  // Next-state and bus multiplexing.
  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    index_d      = index_q;
    buffer_d     = buffer_q;
    bus_address  = cpu_address;
    bus_mem_r_en = cpu_mem_r_en;
    bus_w_data   = cpu_w_data;
    cpu_stall    = 1'b0;
    dma_active   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The trigger write itself still reaches the bus.
        if ((cpu_address == DMA_REG_ADDR) && !cpu_mem_r_en) begin
          page_d  = cpu_w_data;
          index_d = 8'h00;
          state_d = StHalt;
        end
      end
      StHalt: begin
        cpu_stall    = 1'b1;
        dma_active   = 1'b1;
        bus_mem_r_en = 1'b1;
        bus_w_data   = buffer_q;
        // Reads must land on parity 0; insert ALIGN when HALT is already even.
        state_d      = parity_q ? StRead : StAlign;
      end
      StAlign: begin
        cpu_stall    = 1'b1;
        dma_active   = 1'b1;
        bus_mem_r_en = 1'b1;
        bus_w_data   = buffer_q;
        state_d      = StRead;
      end
      StRead: begin
        cpu_stall    = 1'b1;
        dma_active   = 1'b1;
        bus_address  = {page_q, index_q};
        bus_mem_r_en = 1'b1;
        bus_w_data   = buffer_q;
        buffer_d     = bus_r_data;
        state_d      = StWrite;
      end
      StWrite: begin
        cpu_stall    = 1'b1;
        dma_active   = 1'b1;
        bus_address  = OAM_DATA_ADDR;
        bus_mem_r_en = 1'b0;
        bus_w_data   = buffer_q;
        // 8-bit wrap keeps the page fixed.
        index_d      = index_q + 8'h01;
        state_d      = (index_q == 8'hFF) ? StIdle : StRead;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: full transfers with and without the
// alignment cycle, back-to-back triggers, the top page, CPU pass-through and
// reset abort.
module tb_oam_dma_arbiter;

  logic        clock;
  logic        reset;
  logic [15:0] cpu_address;
  logic        cpu_mem_r_en;
  logic [7:0]  cpu_w_data;
  logic [7:0]  cpu_r_data;
  logic        cpu_stall;
  logic [15:0] bus_address;
  logic        bus_mem_r_en;
  logic [7:0]  bus_w_data;
  logic [7:0]  bus_r_data;
  logic        dma_active;

  int n_checks = 0;
  int n_fail   = 0;

  oam_dma_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_address  (cpu_address),
    .cpu_mem_r_en (cpu_mem_r_en),
    .cpu_w_data   (cpu_w_data),
    .cpu_r_data   (cpu_r_data),
    .cpu_stall    (cpu_stall),
    .bus_address  (bus_address),
    .bus_mem_r_en (bus_mem_r_en),
    .bus_w_data   (bus_w_data),
    .bus_r_data   (bus_r_data),
    .dma_active   (dma_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Address-dependent memory contents so each byte is distinguishable.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  assign bus_r_data = mem(bus_address);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cpu(input logic [15:0] a, input logic r, input logic [7:0] d);
    cpu_address  = a;
    cpu_mem_r_en = r;
    cpu_w_data   = d;
  endtask

  // Entered at a negedge with the trigger already driven. Walks every stall
  // cycle against the expected HALT/[ALIGN]/READ/WRITE sequence and returns at
  // the negedge of the first IDLE cycle.
  task automatic do_dma(input logic [7:0] pg, input bit exp_align, input string tag);
    int stalls = 0;
    int bad    = 0;
    int off;
    int j;
    logic [15:0] ra;
    off = exp_align ? 2 : 1;
    @(negedge clock);
    while (cpu_stall && stalls < 600) begin
      if (dma_active !== 1'b1) bad++;
      if (stalls < off) begin
        if (bus_address !== cpu_address || bus_mem_r_en !== 1'b1) bad++;
      end else begin
        j  = stalls - off;
        ra = {pg, 8'(j / 2)};
        if ((j % 2) == 0) begin
          if (bus_address !== ra || bus_mem_r_en !== 1'b1) bad++;
          if (j == 0)   check_eq({tag, "_first_rd"}, bus_address, ra);
          if (j == 510) check_eq({tag, "_last_rd"}, bus_address, ra);
        end else begin
          if (bus_address !== 16'h2004 || bus_mem_r_en !== 1'b0 ||
              bus_w_data !== mem(ra)) bad++;
        end
      end
      // Further writes to the DMA register during a transfer must be ignored.
      if (stalls == 0)  drive_cpu(16'h4014, 1'b0, 8'h77);
      if (stalls == 10) drive_cpu(16'h1234, 1'b1, 8'h00);
      stalls++;
      @(negedge clock);
    end
    check_eq({tag, "_stalls"}, stalls, exp_align ? 514 : 513);
    check_eq({tag, "_seq_errs"}, bad, 0);
    check_eq({tag, "_idle_active"}, dma_active, 1'b0);
    check_eq({tag, "_idle_mirror"}, bus_address, cpu_address);
  endtask

  initial begin
    int writes;
    int guard;

    // Reset state with a write presented: everything mirrors.
    reset = 1'b0;
    drive_cpu(16'h4014, 1'b0, 8'h02);
    #12;
    check_eq("rst_stall", cpu_stall, 1'b0);
    check_eq("rst_active", dma_active, 1'b0);
    check_eq("rst_addr", bus_address, 16'h4014);
    check_eq("rst_ren", bus_mem_r_en, 1'b0);
    check_eq("rst_wdata", bus_w_data, 8'h02);

    // Trigger on the first edge out of reset (parity 0) -> 513 cycles.
    @(negedge clock);
    reset = 1'b1;
    do_dma(8'h02, 1'b0, "dma_p0");

    // Back-to-back trigger in the first IDLE cycle, top page.
    drive_cpu(16'h4014, 1'b0, 8'hFF);
    check_eq("b2b_stall0", cpu_stall, 1'b0);
    do_dma(8'hFF, 1'b0, "dma_ff");
    check_eq("ff_index", dut.index_q, 8'h00);
    check_eq("ff_page", dut.page_q, 8'hFF);

    // Reset, then trigger one cycle later (HALT on parity 0) -> ALIGN, 514.
    reset = 1'b0;
    #3;
    @(negedge clock);
    drive_cpu(16'h1234, 1'b1, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    drive_cpu(16'h4014, 1'b0, 8'h02);
    do_dma(8'h02, 1'b1, "dma_p1");

    // CPU read of the DMA register: pure pass-through, no transfer.
    drive_cpu(16'h4014, 1'b1, 8'h5C);
    #1;
    check_eq("rd_addr", bus_address, 16'h4014);
    check_eq("rd_ren", bus_mem_r_en, 1'b1);
    check_eq("rd_data", cpu_r_data, mem(16'h4014));
    check_eq("rd_stall", cpu_stall, 1'b0);
    repeat (3) @(negedge clock);
    check_eq("rd_active", dma_active, 1'b0);
    check_eq("rd_stall2", cpu_stall, 1'b0);

    // Abort mid-transfer once index reaches 8'h40.
    drive_cpu(16'h4014, 1'b0, 8'h03);
    @(negedge clock);
    drive_cpu(16'h1234, 1'b1, 8'h00);
    guard = 0;
    while (dut.index_q !== 8'h40 && guard < 600) begin
      guard++;
      @(negedge clock);
    end
    check_eq("abort_reach", dut.index_q, 8'h40);
    check_eq("abort_busy", cpu_stall, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_stall", cpu_stall, 1'b0);
    check_eq("abort_active", dma_active, 1'b0);
    check_eq("abort_index", dut.index_q, 8'h00);
    check_eq("abort_mirror", bus_address, 16'h1234);
    writes = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus_address == 16'h2004 && bus_mem_r_en == 1'b0) writes++;
    end
    reset = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (bus_address == 16'h2004 && bus_mem_r_en == 1'b0) writes++;
    end
    check_eq("abort_writes", writes, 0);
    check_eq("abort_idle", dma_active, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
